peregrine_iram0_loader: RTL and testbench

Block-load initiator for the peregrine IRAM0 port. It accepts a load command (start word address, word count, verify flag) and a 32-bit word stream, and drives the IRam0 request signals to write the words into consecutive IRAM0 locations. In verify mode it then reads the range back through IRam0Data and compares a 32-bit additive checksum. It sits between the host/debug DMA path and the IRAM0 memory model, which is the responder on the same port.

---
 rtl/peregrine_iram0_loader.sv | 206 ++++++++++++++++++++
 tb/tb_peregrine_iram0_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peregrine_iram0_loader.sv
// peregrine_iram0_loader: block-load initiator for the IRAM0 port.
// Accepts a load command (start address, word count, verify flag) and a
// 32-bit word stream. It writes the words to consecutive IRAM0 locations,
// wrapping the address. In verify mode it then reads the range back and
// compares the additive checksum of the read data against the written data.
//
// Ports:
//   CLK, Reset_n                       clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_addr/cmd_count/cmd_verify      command payload
//   wr_valid/wr_ready/wr_data          write data stream
//   IRam0Addr/En/Wr/WrData/LoadStore   registered IRAM0 request
//   IRam0Data                          IRAM0 read data (one cycle after sample)
//   busy/done/err/checksum             status and result of the last command
module peregrine_iram0_loader #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 18
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [CW-1:0] cmd_count,
    input  logic          cmd_verify,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] IRam0Addr,
    output logic          IRam0En,
    output logic          IRam0Wr,
    output logic [DW-1:0] IRam0WrData,
    output logic          IRam0LoadStore,
    input  logic [DW-1:0] IRam0Data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] checksum
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(64'd1 << AW);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] start_q, start_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          verify_q, verify_d;
    logic          rd_pend_q;
    logic [DW-1:0] rd_sum_q, rd_sum_d;
    logic [DW-1:0] sum_d;
    logic          err_d;
    logic          en_d, wr_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          cmd_acc_c, beat_acc_c;

    assign cmd_acc_c  = cmd_valid & cmd_ready;
    assign beat_acc_c = wr_valid & wr_ready;

    // Next-state, datapath and request generation
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cur_d    = cur_q;
        count_d  = count_q;
        rem_d    = rem_q;
        verify_d = verify_q;
        rd_sum_d = rd_sum_q;
        sum_d    = checksum;
        err_d    = err;
        en_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = IRam0Addr;
        wdata_d  = IRam0WrData;

        // Read data arrives the cycle after the memory samples a read
        if (rd_pend_q) begin
            rd_sum_d = rd_sum_q + IRam0Data;
        end

        case (state_q)
            IDLE: begin
                if (cmd_acc_c) begin
                    start_d  = cmd_addr;
                    cur_d    = cmd_addr;
                    count_d  = cmd_count;
                    rem_d    = cmd_count;
                    verify_d = cmd_verify;
                    sum_d    = '0;
                    rd_sum_d = '0;
                    err_d    = 1'b0;
                    if (cmd_count == '0) begin
                        state_d = FIN;
                    end else if (cmd_count > MAX_COUNT) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (rem_q == '0) begin
                    // All beats written; the first read goes out immediately
                    if (verify_q) begin
                        en_d    = 1'b1;
                        addr_d  = start_q;
                        cur_d   = start_q + AW'(1);
                        rem_d   = count_q - CW'(1);
                        state_d = (count_q == CW'(1)) ? DRAIN : READ;
                    end else begin
                        state_d = FIN;
                    end
                end else if (beat_acc_c) begin
                    en_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = cur_q;
                    wdata_d = wr_data;
                    sum_d   = checksum + wr_data;
                    cur_d   = cur_q + AW'(1);
                    rem_d   = rem_q - CW'(1);
                end
            end
            READ: begin
                en_d   = 1'b1;
                addr_d = cur_q;
                cur_d  = cur_q + AW'(1);
                rem_d  = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last return is being captured when nothing else is in flight
                if (rd_pend_q && !IRam0En) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (verify_q && (rd_sum_q != checksum)) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            start_q        <= '0;
            cur_q          <= '0;
            count_q        <= '0;
            rem_q          <= '0;
            verify_q       <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_sum_q       <= '0;
            checksum       <= '0;
            err            <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            cmd_ready      <= 1'b0;
            wr_ready       <= 1'b0;
            IRam0Addr      <= '0;
            IRam0En        <= 1'b0;
            IRam0Wr        <= 1'b0;
            IRam0WrData    <= '0;
            IRam0LoadStore <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            cur_q          <= cur_d;
            count_q        <= count_d;
            rem_q          <= rem_d;
            verify_q       <= verify_d;
            rd_pend_q      <= IRam0En & ~IRam0Wr;
            rd_sum_q       <= rd_sum_d;
            checksum       <= sum_d;
            err            <= err_d;
            done           <= (state_q == FIN);
            busy           <= (state_d != IDLE);
            cmd_ready      <= (state_d == IDLE);
            wr_ready       <= (state_d == WRITE) && (rem_d != '0);
            IRam0Addr      <= addr_d;
            IRam0En        <= en_d;
            IRam0Wr        <= wr_d;
            IRam0WrData    <= wdata_d;
            IRam0LoadStore <= en_d;
        end
    end

endmodule

// File: tb/tb_peregrine_iram0_loader.sv
// Scoreboard bench for peregrine_iram0_loader with an IRAM0 memory responder.
module tb_peregrine_iram0_loader;

    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 18;
    localparam int unsigned DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          Reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          cmd_verify = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] IRam0Addr;
    logic          IRam0En;
    logic          IRam0Wr;
    logic [DW-1:0] IRam0WrData;
    logic          IRam0LoadStore;
    logic [DW-1:0] IRam0Data;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] checksum;

    peregrine_iram0_loader #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK            (CLK),
        .Reset_n        (Reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_count      (cmd_count),
        .cmd_verify     (cmd_verify),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .IRam0Addr      (IRam0Addr),
        .IRam0En        (IRam0En),
        .IRam0Wr        (IRam0Wr),
        .IRam0WrData    (IRam0WrData),
        .IRam0LoadStore (IRam0LoadStore),
        .IRam0Data      (IRam0Data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .checksum       (checksum)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] sum;
        int            cyc;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    int    poke_cyc = -10;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata = '0;

    assign IRam0Data = rdata;

    // IRAM0 responder; also applies a one-shot corruption at a chosen edge
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (IRam0En && IRam0Wr) mem[IRam0Addr] <= IRam0WrData;
        if (IRam0En && !IRam0Wr) rdata <= mem[IRam0Addr];
        if (cyc == poke_cyc) mem[poke_addr] <= mem[poke_addr] ^ 32'h0000_0100;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops expected accesses and completions as the DUT presents them
    always @(negedge CLK) begin : monitor
        acc_t  e;
        done_t d;
        if (Reset_n) begin
            if (IRam0En) begin
                check("loadstore", 64'(IRam0LoadStore), 64'd1);
                if (acc_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_access: got addr 0x%0h wr %0b expected no access", IRam0Addr, IRam0Wr);
                end else begin
                    e = acc_q.pop_front();
                    check("acc_wr", 64'(IRam0Wr), 64'(e.wr));
                    check("acc_addr", 64'(IRam0Addr), 64'(e.addr));
                    if (e.wr) check("acc_data", 64'(IRam0WrData), 64'(e.data));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    d = done_q.pop_front();
                    check("done_err", 64'(err), 64'(d.err));
                    check("done_checksum", 64'(checksum), 64'(d.sum));
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                end
            end
        end
    end

    task automatic run_cmd(input logic [AW-1:0] addr, input logic [CW-1:0] count,
                           input bit verify, input int unsigned gap_mask,
                           input bit corrupt, input int abort_at, input bit seq_data);
        logic [DW-1:0] data[$];
        logic [DW-1:0] sum;
        int    last_cyc, acc_cyc, guard, i, n;
        bit    ok_cmd, gapped;
        done_t d;
        sum = '0; last_cyc = 0; guard = 0; i = 0; gapped = 0;
        n = int'(count);
        ok_cmd = (n != 0) && (n <= int'(DEPTH));
        poke_cyc = -10;
        if (ok_cmd) begin
            for (int k = 0; k < n; k++) begin
                data.push_back(seq_data ? DW'(k + 1) : DW'($urandom));
                sum += data[k];
            end
            for (int k = 0; k < n; k++) acc_q.push_back('{1'b1, addr + AW'(k), data[k]});
            if (verify) for (int k = 0; k < n; k++) acc_q.push_back('{1'b0, addr + AW'(k), DW'(0)});
        end

        @(negedge CLK);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_count = count; cmd_verify = verify;
        while (!cmd_ready && guard < 100) begin @(negedge CLK); guard++; end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL cmd_accept: got cmd_ready 0 expected 1 within 100 cycles");
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        if (!ok_cmd) begin
            d.err = (n != 0); d.sum = '0; d.cyc = acc_cyc + 1;
            done_q.push_back(d);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        if (!ok_cmd) return;

        guard = 0;
        while (i < n && guard < 200) begin
            if (abort_at > 0 && i == abort_at) break;
            if (i < 32 && gap_mask[i] && !gapped) begin
                wr_valid = 1'b0; gapped = 1; guard++;
            end else begin
                wr_valid = 1'b1; wr_data = data[i];
                if (wr_ready) begin last_cyc = cyc + 1; i++; gapped = 0; end
                else guard++;
            end
            @(negedge CLK);
        end

        if (abort_at > 0 && i == abort_at) begin
            #2;
            check("en_before_reset", 64'(IRam0En), 64'd1);
            Reset_n = 1'b0;
            #1;
            check("en_async_reset", 64'(IRam0En), 64'd0);
            check("busy_async_reset", 64'(busy), 64'd0);
            check("ready_async_reset", 64'({cmd_ready, wr_ready}), 64'd0);
            wr_valid = 1'b0;
            acc_q.delete();
            done_q.delete();
            repeat (2) @(negedge CLK);
            Reset_n = 1'b1;
            return;
        end

        wr_valid = 1'b0;
        if (i < n) begin
            checks++;
            $display("FAIL beat_accept: got %0d beats accepted expected %0d", i, n);
            return;
        end
        if (corrupt) begin
            poke_addr = addr + AW'(2);
            poke_cyc  = last_cyc + 1;
        end
        d.err = corrupt;
        d.sum = sum;
        d.cyc = verify ? last_cyc + n + 3 : last_cyc + 2;
        done_q.push_back(d);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((acc_q.size() != 0 || done_q.size() != 0) && guard < 1000) begin
            @(negedge CLK); #1; guard++;
        end
        check("queues_drained", 64'(acc_q.size() + done_q.size()), 64'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin : main
        bit          v;
        int unsigned cnt;
        #12;
        check("rst_ctrl", 64'({cmd_ready, wr_ready, busy, done, err, IRam0En, IRam0Wr, IRam0LoadStore}), 64'd0);
        check("rst_addr", 64'(IRam0Addr), 64'd0);
        check("rst_wrdata", 64'(IRam0WrData), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        @(posedge CLK); #2;
        Reset_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(cmd_ready), 64'd0);
        @(posedge CLK); #1;
        check("ready_after_release", 64'(cmd_ready), 64'd1);

        // Plain load, sequential data 1..4
        run_cmd(AW'(17'h00010), CW'(4), 1'b0, 0, 1'b0, 0, 1'b1);
        wait_idle();
        // Verify load with three idle beats
        run_cmd(AW'($urandom), CW'(8), 1'b1, 32'h94, 1'b0, 0, 1'b0);
        wait_idle();
        // Address wrap in both phases
        run_cmd(AW'(17'h1FFFE), CW'(4), 1'b1, 0, 1'b0, 0, 1'b0);
        wait_idle();
        // Memory corrupted between write and read phases
        run_cmd(AW'($urandom), CW'(6), 1'b1, 0, 1'b1, 0, 1'b0);
        wait_idle();
        // Degenerate counts
        run_cmd(AW'(17'h00100), CW'(0), 1'b1, 0, 1'b0, 0, 1'b0);
        wait_idle();
        run_cmd(AW'(17'h00200), CW'(18'h20001), 1'b1, 0, 1'b0, 0, 1'b0);
        wait_idle();
        // Reset in the middle of a write, then a normal command
        run_cmd(AW'(17'h00400), CW'(10), 1'b0, 0, 1'b0, 5, 1'b0);
        run_cmd(AW'(17'h00400), CW'(3), 1'b1, 0, 1'b0, 0, 1'b0);
        wait_idle();
        // Random commands
        for (int t = 0; t < 12; t++) begin
            v   = 1'($urandom_range(0, 1));
            cnt = $urandom_range(1, 20);
            run_cmd(AW'($urandom), CW'(cnt), v, $urandom & 32'h0004_9249,
                    v && cnt >= 3 && ($urandom_range(0, 2) == 0), 0, 1'b0);
            wait_idle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
